// File: rtl/rr_mux_pkg.sv
// Shared constants and helpers for the round-robin multiplexer slice.
package rr_mux_pkg;

  localparam int MAX_N_CH = 16;

  // Select width for n channels; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_mux_slice_pick.sv
// Combinational arbiter: round-robin scan from ptr, or lowest index when rr_mode=0.
module rr_priority_pick
  import rr_mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int SELW = 2
) (
  input  logic [N_CH-1:0] req,
  input  logic [SELW-1:0] ptr,
  input  logic            rr_mode,
  output logic [N_CH-1:0] grant,
  output logic [SELW-1:0] grant_idx,
  output logic            any_grant
);

  function automatic int wrap_idx(input int base, input int k);
    int c;
    c = base + k;
    return (c >= N_CH) ? c - N_CH : c;
  endfunction

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (!any_grant && req[wrap_idx(rr_mode ? int'(ptr) : 0, k)]) begin
        grant[wrap_idx(rr_mode ? int'(ptr) : 0, k)] = 1'b1;
        grant_idx = SELW'(wrap_idx(rr_mode ? int'(ptr) : 0, k));
        any_grant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mux_slice.sv
// N-channel to 1 multiplexer with internal arbitration and a one-entry output register.
// Handshake: a word moves when valid && ready are both high at a rising edge.
module rr_mux_slice
  import rr_mux_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int WIDTH = 8,
  parameter  int RR    = 1,
  localparam int SELW  = clog2_min1(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SELW-1:0]       out_sel,
  input  logic                  out_ready
);

  localparam logic RR_MODE = (RR != 0) ? 1'b1 : 1'b0;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_sel_q,   out_sel_d;
  logic [SELW-1:0]  ptr_q,       ptr_d;

  logic [N_CH-1:0]  grant;
  logic [SELW-1:0]  grant_idx;
  logic             any_grant;
  logic             load;

  rr_priority_pick #(
    .N_CH (N_CH),
    .SELW (SELW)
  ) u_pick (
    .req       (in_valid),
    .ptr       (ptr_q),
    .rr_mode   (RR_MODE),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // Empty register, or one draining this cycle, can take a new word.
  assign load     = !out_valid_q || out_ready;
  assign in_ready = (load && !rst) ? grant : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = any_grant;
      if (any_grant) begin
        out_sel_d = grant_idx;
        for (int i = 0; i < N_CH; i++) begin
          if (grant[i]) out_data_d = in_data[i*WIDTH +: WIDTH];
        end
        // Explicit wrap keeps ptr inside 0..N_CH-1 for non-power-of-2 N_CH.
        if (RR_MODE) ptr_d = (grant_idx == SELW'(N_CH - 1)) ? '0 : grant_idx + SELW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_slice.sv
// Bench for rr_mux_slice: round-robin, fixed-priority and three-channel instances.
module tb_rr_mux_slice;

  logic clk;
  logic rst;

  // Main instance: N_CH=4, RR=1
  logic [3:0]  v4, ready4;
  logic [31:0] d4;
  logic        ov4, or4;
  logic [7:0]  od4;
  logic [1:0]  os4;

  // Fixed-priority instance: N_CH=4, RR=0
  logic [3:0]  v_fp, ready_fp;
  logic [31:0] d_fp;
  logic        ov_fp, or_fp;
  logic [7:0]  od_fp;
  logic [1:0]  os_fp;

  // Three-channel instance: N_CH=3, RR=1
  logic [2:0]  v3, ready3;
  logic [23:0] d3;
  logic        ov3, or3;
  logic [7:0]  od3;
  logic [1:0]  os3;

  rr_mux_slice #(.N_CH(4), .WIDTH(8), .RR(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(v4), .in_data(d4), .in_ready(ready4),
    .out_valid(ov4), .out_data(od4), .out_sel(os4), .out_ready(or4)
  );

  rr_mux_slice #(.N_CH(4), .WIDTH(8), .RR(0)) u_fp (
    .clk(clk), .rst(rst), .in_valid(v_fp), .in_data(d_fp), .in_ready(ready_fp),
    .out_valid(ov_fp), .out_data(od_fp), .out_sel(os_fp), .out_ready(or_fp)
  );

  rr_mux_slice #(.N_CH(3), .WIDTH(8), .RR(1)) u_n3 (
    .clk(clk), .rst(rst), .in_valid(v3), .in_data(d3), .in_ready(ready3),
    .out_valid(ov3), .out_data(od3), .out_sel(os3), .out_ready(or3)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard: {out_sel, out_data} expected, in acceptance order
  logic [9:0] exp_q[$];
  int         m_ptr = 0;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  exp_ready;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] rr_pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (p + k) % 4;
      if (v[c]) return 4'(1 << c);
    end
    return 4'b0000;
  endfunction

  // Driver for the main instance: one cycle, checked at the falling edge.
  task automatic cyc4(input logic r, input logic [3:0] v, input logic [31:0] d,
                      input logic o, input logic [3:0] exp_in, input bit use_model);
    logic [3:0] exp_rdy;
    logic       m_ov;
    logic       load;
    rst = r; v4 = v; d4 = d; or4 = o;
    @(negedge clk);
    m_ov = (exp_q.size() != 0);
    load = !m_ov || o;
    exp_rdy = use_model ? ((load && !r) ? rr_pick(v, m_ptr) : 4'b0000) : exp_in;
    check("in_ready", 32'(ready4), 32'(exp_rdy));
    check("out_valid", 32'(ov4), 32'(m_ov));
    if (m_ov) begin
      check("out_word", 32'({os4, od4}), 32'(exp_q[0]));
      if (o) void'(exp_q.pop_front());
    end
    for (int i = 0; i < 4; i++) begin
      if (exp_rdy[i]) begin
        exp_q.push_back({2'(i), d[i*8 +: 8]});
        m_ptr = (i == 3) ? 0 : i + 1;
      end
    end
    if (r) begin
      exp_q.delete();
      m_ptr = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0001};
    vecs[1]  = '{4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0010};
    vecs[2]  = '{4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0100};
    vecs[3]  = '{4'b1111, 32'hA3A2A1A0, 1'b1, 4'b1000};
    vecs[4]  = '{4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0001};
    vecs[5]  = '{4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0010};
    vecs[6]  = '{4'b0000, 32'hA3A2A1A0, 1'b1, 4'b0000};
    vecs[7]  = '{4'b0100, 32'hA3A25CA0, 1'b1, 4'b0100};
    vecs[8]  = '{4'b0100, 32'hA3A25DA0, 1'b0, 4'b0000};
    vecs[9]  = '{4'b0100, 32'hA3A25DA0, 1'b0, 4'b0000};
    vecs[10] = '{4'b0100, 32'hA3A25DA0, 1'b0, 4'b0000};
    vecs[11] = '{4'b0100, 32'hA3A25DA0, 1'b1, 4'b0100};
    vecs[12] = '{4'b0000, 32'hA3A25DA0, 1'b1, 4'b0000};

    v_fp = '0; d_fp = '0; or_fp = 1'b1;
    v3 = '0; d3 = '0; or3 = 1'b1;

    // Reset held two cycles with every channel requesting
    rst = 1'b1; v4 = 4'b1111; d4 = 32'hA3A2A1A0; or4 = 1'b1;
    @(posedge clk);
    #1;
    check("rst_out_data", 32'(od4), 32'h0);
    check("rst_out_sel", 32'(os4), 32'h0);
    cyc4(1'b1, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0000, 1'b0);
    cyc4(1'b1, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0000, 1'b0);

    // Round-robin sequence and backpressure from the table
    for (int i = 0; i < 13; i++)
      cyc4(1'b0, vecs[i].valid, vecs[i].data, vecs[i].ordy, vecs[i].exp_ready, 1'b0);

    // Random traffic against the reference arbiter
    for (int i = 0; i < 200; i++)
      cyc4(1'b0, 4'($urandom_range(0, 15)), $urandom(), ($urandom_range(0, 3) != 0), 4'b0000, 1'b1);

    // Reset while a word is stalled in the output register
    cyc4(1'b0, 4'b0001, 32'h000000E7, 1'b1, 4'b0000, 1'b1);
    cyc4(1'b0, 4'b0001, 32'h000000E8, 1'b0, 4'b0000, 1'b1);
    cyc4(1'b1, 4'b1111, 32'hA3A2A1A0, 1'b0, 4'b0000, 1'b0);
    check("midrst_out_valid", 32'(ov4), 32'h0);
    check("midrst_out_data", 32'(od4), 32'h0);
    check("midrst_out_sel", 32'(os4), 32'h0);
    cyc4(1'b0, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0001, 1'b0);
    cyc4(1'b0, 4'b0000, 32'hA3A2A1A0, 1'b1, 4'b0000, 1'b0);
    v4 = 4'b0000;

    // Fixed priority: channel 1 always beats channel 3
    v_fp = 4'b1010; d_fp = 32'h44332211;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("fp_in_ready", 32'(ready_fp), 32'h2);
      if (k > 0) begin
        check("fp_out_sel", 32'(os_fp), 32'h1);
        check("fp_out_data", 32'(od_fp), 32'h22);
      end
      @(posedge clk);
      #1;
    end
    v_fp = 4'b0000;

    // Three channels: pointer wraps from 2 back to 0
    v3 = 3'b100; d3 = 24'hC2C1C0;
    @(negedge clk);
    check("n3_ready_a", 32'(ready3), 32'h4);
    @(posedge clk);
    #1;
    v3 = 3'b101;
    @(negedge clk);
    check("n3_ready_b", 32'(ready3), 32'h1);
    check("n3_sel_b", 32'(os3), 32'h2);
    check("n3_data_b", 32'(od3), 32'hC2);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("n3_ready_c", 32'(ready3), 32'h4);
    check("n3_sel_c", 32'(os3), 32'h0);
    check("n3_data_c", 32'(od3), 32'hC0);
    @(posedge clk);
    #1;
    v3 = 3'b000;
    @(negedge clk);
    check("n3_sel_d", 32'(os3), 32'h2);
    check("n3_data_d", 32'(od3), 32'hC2);
    check("n3_valid_d", 32'(ov3), 32'h1);
    @(posedge clk);
    #1;

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
